// File: rtl/note_sequencer_if.sv
// Song-buffer handshake between the note sequencer and the song FIFO.
//   fifo_ready : FIFO holds at least one word (FIFO -> sequencer)
//   fifo_data  : song word, valid the cycle after a read_en pulse
//                [11:10] length code, [9:2] notes, [1:0] shift
//   read_en    : one-cycle pop strobe (sequencer -> FIFO)
// master = sequencer side, slave = FIFO side.
interface note_sequencer_if;
  logic        fifo_ready;
  logic [11:0] fifo_data;
  logic        read_en;

  modport master (
    input  fifo_ready,
    input  fifo_data,
    output read_en
  );

  modport slave (
    output fifo_ready,
    output fifo_data,
    input  read_en
  );
endinterface

// File: rtl/note_sequencer.sv
// Timed playback controller for the sound generator.
// Pops song words from the song buffer, holds each note for (len+1) beats
// minus a silent articulation gap, and handles start/pause/stop plus the
// end-of-song marker (12'hFFF).
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-high (name kept for compatibility)
//   start      one-cycle pulse, begin playback (ignored while playing)
//   pause      level, freeze playback while high
//   stop       one-cycle pulse, abort playback
//   fifo       song-buffer handshake (master side)
//   notes      note bitmap to the sound generator
//   shift      octave shift to the sound generator
//   playing    high in every state except IDLE
//   done       one-cycle pulse on end-of-song
//   beat_tick  one-cycle pulse at each beat boundary in PLAY
// All outputs are registered.
module note_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  stop,
  note_sequencer_if.master      fifo,
  output logic [7:0]            notes,
  output logic [1:0]            shift,
  output logic                  playing,
  output logic                  done,
  output logic                  beat_tick
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_PLAY  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [11:0]      END_MARK  = 12'hFFF;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] PHASE_MAX = CNT_W'(BEAT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_phase;   // position within the current beat
  logic             r_frozen;  // current cycle is a paused (non-advancing) cycle
  logic [7:0]       r_note;    // note of the word being played
  logic [1:0]       r_shft;
  logic             r_read_en;
  logic [7:0]       r_notes;
  logic [1:0]       r_shift;
  logic             r_playing;
  logic             r_done;
  logic             r_beat_tick;

  logic [2:0]       w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_phase;
  logic [7:0]       w_note;
  logic [1:0]       w_shft;
  logic             w_read_en;
  logic             w_done;
  logic             w_frozen;
  logic             w_sounding;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_phase   = r_phase;
    w_note    = r_note;
    w_shft    = r_shft;
    w_read_en = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_state = S_FETCH;
      end
      S_FETCH: begin
        if (fifo.fifo_ready) begin
          w_read_en = 1'b1;
          w_state   = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state = S_LOAD;
      end
      S_LOAD: begin
        if (fifo.fifo_data == END_MARK) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_note  = fifo.fifo_data[9:2];
          w_shft  = fifo.fifo_data[1:0];
          w_cnt   = CNT_W'((32'(fifo.fifo_data[11:10]) + 32'd1) * BEAT_CYCLES
                           - GAP_CYCLES);
          w_phase = '0;
          w_state = S_PLAY;
        end
      end
      S_PLAY: begin
        // A frozen cycle consumed no time, so it does not advance the count.
        if (!r_frozen) begin
          if (r_cnt == CNT_ONE) begin
            w_cnt   = GAP_LOAD;
            w_state = S_GAP;
          end else begin
            w_cnt   = r_cnt - CNT_ONE;
            w_phase = (r_phase == PHASE_MAX) ? '0 : r_phase + CNT_ONE;
          end
        end
      end
      S_GAP: begin
        if (!r_frozen) begin
          if (r_cnt == CNT_ONE) begin
            w_cnt   = '0;
            w_state = S_FETCH;
          end else begin
            w_cnt = r_cnt - CNT_ONE;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // stop wins over everything; a word already popped is simply dropped.
    if (stop && (r_state != S_IDLE)) begin
      w_state   = S_IDLE;
      w_read_en = 1'b0;
      w_done    = 1'b0;
      w_cnt     = '0;
      w_phase   = '0;
    end

    // pause only bites once the next cycle would be timed (PLAY/GAP), which
    // lets an in-flight fetch complete and freeze at the entry to PLAY.
    w_frozen   = pause && ((w_state == S_PLAY) || (w_state == S_GAP));
    w_sounding = (w_state == S_PLAY) && !pause;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_frozen    <= 1'b0;
      r_note      <= '0;
      r_shft      <= '0;
      r_read_en   <= 1'b0;
      r_notes     <= '0;
      r_shift     <= '0;
      r_playing   <= 1'b0;
      r_done      <= 1'b0;
      r_beat_tick <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_phase     <= w_phase;
      r_frozen    <= w_frozen;
      r_note      <= w_note;
      r_shft      <= w_shft;
      r_read_en   <= w_read_en;
      r_notes     <= w_sounding ? w_note : '0;
      r_shift     <= w_sounding ? w_shft : '0;
      r_playing   <= (w_state != S_IDLE);
      r_done      <= w_done;
      r_beat_tick <= w_sounding && (w_phase == '0);
    end
  end

  assign fifo.read_en = r_read_en;
  assign notes        = r_notes;
  assign shift        = r_shift;
  assign playing      = r_playing;
  assign done         = r_done;
  assign beat_tick    = r_beat_tick;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Timed playback controller for the sound generator (notes[7:0] + shift[1:0] datapath).
- Pops song words from the song-buffer FIFO using a ready/read_en handshake.
- Holds each note for a programmed number of beats, then inserts a short silent articulation gap.
- Handles start/pause/stop and the end-of-song marker, so the play/game mode tops no longer gate the buffer output combinationally.

Parameters:
BEAT_CYCLES, 25_000_000, clk cycles per beat (250 ms at 100 MHz); must be > GAP_CYCLES.
GAP_CYCLES, 2_500_000, silent cycles at the end of every note.
CNT_W, 27, counter width; must hold 4*BEAT_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-high (asserted = 1); name kept per codebase port naming
start  in  1  one-cycle pulse: begin playback
pause  in  1  level: freeze playback while high
stop  in  1  one-cycle pulse: abort playback
fifo_ready  in  1  song buffer holds at least one word
fifo_data  in  12  song word: [11:10] len code, [9:2] notes, [1:0] shift
read_en  out  1  one-cycle pop strobe to the song buffer
notes  out  8  note one-hot/bitmap to the sound generator
shift  out  2  octave shift to the sound generator
playing  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on end-of-song
beat_tick  out  1  one-cycle pulse at each beat boundary while sounding

Behaviour:
- All outputs are registered. Reset values: read_en=0, notes=0, shift=0, playing=0, done=0, beat_tick=0, state=IDLE, counters=0.
- Reset is synchronous and overrides everything, including mid-note; the next edge returns the block to IDLE.
- FIFO contract: data is valid on the cycle after the read_en pulse. read_en is only asserted when fifo_ready=1.
- Song word decode:
  - Note length = (len+1) beats, so 1..4 beats.
  - notes==0 is a rest: silent for the full length.
  - Word 12'hFFF is the end marker.
- States:
  - IDLE: outputs silent. On start, go to FETCH.
  - FETCH: if fifo_ready, pulse read_en and go to WAIT. Otherwise stall in FETCH with the outputs silent (underrun, no error).
  - WAIT: one cycle for the FIFO read latency.
  - LOAD: capture fifo_data.
    - End marker: done=1 for one cycle, go to IDLE.
    - Otherwise: load cnt=(len+1)*BEAT_CYCLES-GAP_CYCLES, drive notes/shift, go to PLAY.
  - PLAY: decrement cnt each cycle. At cnt==1, go to GAP with cnt=GAP_CYCLES and notes/shift=0.
  - GAP: decrement cnt. At cnt==1, go to FETCH.
- Timing per note:
  - Sounding cycles = (len+1)*BEAT_CYCLES - GAP_CYCLES.
  - Gap = GAP_CYCLES.
  - Fixed fetch overhead = 3 cycles (FETCH, WAIT, LOAD) with a ready FIFO.
- beat_tick pulses in PLAY whenever the elapsed count since LOAD is a multiple of BEAT_CYCLES, and on the first PLAY cycle.
- pause (while PLAY or GAP):
  - Counters freeze; notes/shift are forced to 0.
  - On release, the held note resumes with its remaining count.
  - In FETCH/WAIT/LOAD the fetch completes, then the block freezes at the entry to PLAY.
  - Ignored in IDLE.
- stop: from any non-IDLE state, go to IDLE on the next edge with outputs silent. No done pulse. A word already popped in WAIT/LOAD is discarded. No effect in IDLE.
- Simultaneous events:
  - Priority is stop > pause > start.
  - start while playing=1 is ignored.
  - start and stop in the same cycle in IDLE: remain in IDLE.
- notes/shift change only on LOAD, PLAY→GAP, pause entry/exit, stop, and reset. No glitches between these events.

Test Plan:
1. BEAT_CYCLES=8, GAP_CYCLES=2; FIFO holds {len=0, notes=8'h01, shift=1}, then 12'hFFF; start → read_en at cycle 1; notes=01/shift=1 for exactly 6 cycles; 2 silent cycles; FETCH; done pulse once; playing falls.
2. Word len=3, notes=8'h80 → notes=80 for 30 cycles; beat_tick at sounding cycles 0, 8, 16, 24.
3. Rest word (notes=0, len=1) between two notes → 14+2 silent cycles; read_en issued exactly once per word.
4. pause raised for 5 cycles at sounding cycle 3 of a 6-cycle note → notes=0 during the pause; note resumes for the remaining 3 cycles; total note span 11 cycles.
5. fifo_ready=0 after the first note → block holds in FETCH, silent, read_en=0, playing=1; fifo_ready=1 → read_en next cycle.
6. stop asserted the same cycle as read_en; separately, rst_n=1 mid-PLAY → IDLE next edge, all outputs 0, no done pulse; the popped word is never played.
